// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// Bit reversal is sized for the largest supported frame (4096 points).
package fft_reorder_pkg;

   localparam int MAX_LOG2_N = 12;

   typedef struct packed {
      logic full;
      logic mode;
   } bank_state_t;

   function automatic int frame_len(input int log2_n);
      return 1 << log2_n;
   endfunction

   // Reverses the low 'width' bits of idx; bits above width come back as zero.
   function automatic logic [MAX_LOG2_N-1:0] bitrev(input logic [MAX_LOG2_N-1:0] idx,
                                                    input int width);
      logic [MAX_LOG2_N-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_LOG2_N; i++) begin
         if (i < width) r[4'(i)] = idx[4'(width - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/reorder_bank_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register holds its value whenever rd_en is low.
module reorder_bank_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Only the read register is cleared so the output reads zero out of reset.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fft_bitrev_reorder_buf.sv
// Ping-pong frame buffer: writes N samples in natural order, then replays the
// frame in natural or bit-reversed order while the other bank fills.
module fft_bitrev_reorder_buf
   import fft_reorder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LOG2_N     = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_bitrev,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [LOG2_N-1:0]     m_idx,
   output logic                  m_last,
   output logic                  frame_err
);

   localparam int N = frame_len(LOG2_N);
   localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

   bank_state_t       bank_q [2];
   logic              wr_sel;
   logic              rd_sel;
   logic [LOG2_N-1:0] wr_cnt;
   logic [LOG2_N-1:0] rd_cnt;
   logic [LOG2_N-1:0] rd_addr;
   logic              wr_fire;
   logic              wr_last;
   logic              rd_issue;
   logic              rd_last;

   assign s_ready  = !bank_q[wr_sel].full;
   assign wr_fire  = s_valid && s_ready;
   assign wr_last  = (wr_cnt == LAST_IDX);
   assign rd_last  = (rd_cnt == LAST_IDX);
   assign rd_issue = bank_q[rd_sel].full && (!m_valid || m_ready);
   assign rd_addr  = bank_q[rd_sel].mode ? LOG2_N'(bitrev(MAX_LOG2_N'(rd_cnt), LOG2_N))
                                         : rd_cnt;

   // The RAM read register doubles as the m_data output register.
   reorder_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (LOG2_N + 1)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire),
      .wr_addr ({wr_sel, wr_cnt}),
      .wr_data (s_data),
      .rd_en   (rd_issue),
      .rd_addr ({rd_sel, rd_addr}),
      .rd_data (m_data)
   );

   // Writer only ever targets an empty bank and the reader a full one, so a
   // same-cycle set and clear always land on different banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
         bank_q[0] <= '0;
         bank_q[1] <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         m_idx     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= wr_fire && (s_last != wr_last);
         if (wr_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == '0) bank_q[wr_sel].mode <= cfg_bitrev;
            if (wr_last) begin
               bank_q[wr_sel].full <= 1'b1;
               wr_sel              <= !wr_sel;
            end
         end
         if (rd_issue) begin
            rd_cnt  <= rd_cnt + 1'b1;
            m_valid <= 1'b1;
            m_idx   <= rd_addr;
            m_last  <= rd_last;
            if (rd_last) begin
               bank_q[rd_sel].full <= 1'b0;
               rd_sel              <= !rd_sel;
            end
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder_buf.sv
// Bench for the reorder buffer: an 8-point instance for the directed scenarios
// and a 512-point instance for random frames against a bit-reversal model.
module tb_fft_bitrev_reorder_buf;

   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          cfg_bitrev = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready, m_valid, m_last, frame_err;
   logic [DW-1:0] m_data;
   logic [2:0]    m_idx;

   logic          cfg_bitrev_9 = 1'b0, s_valid_9 = 1'b0, s_last_9 = 1'b0, m_ready_9 = 1'b0;
   logic [DW-1:0] s_data_9 = '0;
   logic          s_ready_9, m_valid_9, m_last_9, frame_err_9;
   logic [DW-1:0] m_data_9;
   logic [8:0]    m_idx_9;

   fft_bitrev_reorder_buf #(.DATA_WIDTH(DW), .LOG2_N(3)) dut (
      .clk(clk), .rst(rst), .cfg_bitrev(cfg_bitrev), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_idx(m_idx), .m_last(m_last), .frame_err(frame_err));

   fft_bitrev_reorder_buf #(.DATA_WIDTH(DW), .LOG2_N(9)) dut9 (
      .clk(clk), .rst(rst), .cfg_bitrev(cfg_bitrev_9), .s_valid(s_valid_9), .s_ready(s_ready_9),
      .s_data(s_data_9), .s_last(s_last_9), .m_valid(m_valid_9), .m_ready(m_ready_9),
      .m_data(m_data_9), .m_idx(m_idx_9), .m_last(m_last_9), .frame_err(frame_err_9));

   int checks = 0;
   int fails  = 0;

   logic [DW-1:0] got_data[$];
   int            got_idx[$];
   bit            got_last[$];
   int            got_cyc[$];
   logic [DW-1:0] got9_data[$];
   int            got9_idx[$];
   bit            got9_last[$];
   int            cyc = 0, err_seen = 0, err9_seen = 0, stall_viol = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic [2:0]    prev_idx;

   // Outputs are observed mid-cycle, where the upcoming edge's handshake is already settled.
   always @(negedge clk) begin
      cyc++;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_idx !== prev_idx))
         stall_viol++;
      prev_stall = !rst && m_valid && !m_ready;
      prev_data  = m_data;
      prev_idx   = m_idx;
      if (frame_err === 1'b1) err_seen++;
      if (frame_err_9 === 1'b1) err9_seen++;
      if (!rst && m_valid === 1'b1 && m_ready) begin
         got_data.push_back(m_data);
         got_idx.push_back(int'(m_idx));
         got_last.push_back(m_last);
         got_cyc.push_back(cyc);
      end
      if (!rst && m_valid_9 === 1'b1 && m_ready_9) begin
         got9_data.push_back(m_data_9);
         got9_idx.push_back(int'(m_idx_9));
         got9_last.push_back(m_last_9);
      end
   end

   function automatic int bitrev_model(input int k, input int bits);
      int r = 0;
      int x = k;
      for (int i = 0; i < bits; i++) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
   endfunction

   task automatic clear_got();
      got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit cfg,
                            output int waited);
      bit acc;
      waited = 0;
      s_valid = 1'b1; s_data = d; s_last = last; cfg_bitrev = cfg;
      do begin
         acc = s_ready;
         @(posedge clk); #1;
         waited++;
      end while (!acc && waited < 200);
      s_valid = 1'b0; s_last = 1'b0;
      if (!acc) begin
         checks++; fails++;
         $display("[TB] FAIL send_beat: s_ready=0 for %0d cycles, required 1", waited);
      end
   endtask

   task automatic send_beat9(input logic [DW-1:0] d, input bit last);
      bit acc;
      int waited = 0;
      s_valid_9 = 1'b1; s_data_9 = d; s_last_9 = last; cfg_bitrev_9 = 1'b1;
      do begin
         acc = s_ready_9;
         @(posedge clk); #1;
         waited++;
      end while (!acc && waited < 200);
      s_valid_9 = 1'b0; s_last_9 = 1'b0;
      if (!acc) begin
         checks++; fails++;
         $display("[TB] FAIL send_beat9: s_ready=0 for %0d cycles, required 1", waited);
      end
   endtask

   task automatic wait_got(input int n);
      int k = 0;
      while (got_data.size() < n && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      if (got_data.size() < n) begin
         checks++; fails++;
         $display("[TB] FAIL wait_got: got %0d samples, required %0d", got_data.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({s_ready, m_valid, m_last, m_idx, frame_err} !== 7'b1000000) begin
         fails++;
         $display("[TB] FAIL reset_ctrl: got {s_ready,m_valid,m_last,m_idx,frame_err}=%b, required 1000000",
                  {s_ready, m_valid, m_last, m_idx, frame_err});
      end
      checks++;
      if (m_data !== '0) begin
         fails++;
         $display("[TB] FAIL reset_data: got %h, required 0", m_data);
      end
      checks++;
      if ({s_ready_9, m_valid_9} !== 2'b10) begin
         fails++;
         $display("[TB] FAIL reset_n9: got {s_ready,m_valid}=%b, required 10", {s_ready_9, m_valid_9});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_bitrev_basic();
      int w, a, e0;
      e0 = err_seen;
      clear_got();
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) send_beat(DW'(k), k == 7, 1'b1, w);
      checks++;
      if (m_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL latency_early: m_valid=%b at accept edge, required 0", m_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== '0) begin
         fails++;
         $display("[TB] FAIL latency_first: m_valid=%b m_data=%0h, required 1 and 0", m_valid, m_data);
      end
      wait_got(8);
      for (int i = 0; i < 8; i++) begin
         a = bitrev_model(i, 3);
         checks++;
         if (got_data[i] !== DW'(a) || got_idx[i] !== a || got_last[i] !== (i == 7)) begin
            fails++;
            $display("[TB] FAIL bitrev_basic[%0d]: got data=%0h idx=%0d last=%0b, required %0h %0d %0b",
                     i, got_data[i], got_idx[i], got_last[i], a, a, i == 7);
         end
      end
      checks++;
      if (err_seen - e0 != 0) begin
         fails++;
         $display("[TB] FAIL bitrev_basic_err: got %0d frame_err pulses, required 0", err_seen - e0);
      end
   endtask

   task automatic test_mode_switch();
      logic [DW-1:0] sent[16];
      bit mode[2] = '{1'b0, 1'b1};
      int w, a;
      clear_got();
      m_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         sent[k] = $urandom;
         // First beat of each frame sets the mode; later beats flip cfg_bitrev to show it is ignored.
         send_beat(sent[k], (k % 8) == 7, (k % 8 == 0) ? mode[k / 8] : bit'((k % 2) ^ (k / 8)), w);
      end
      wait_got(16);
      for (int i = 0; i < 16; i++) begin
         a = mode[i / 8] ? bitrev_model(i % 8, 3) : i % 8;
         checks++;
         if (got_data[i] !== sent[(i / 8) * 8 + a] || got_idx[i] !== a || got_last[i] !== (i % 8 == 7)) begin
            fails++;
            $display("[TB] FAIL mode_switch[%0d]: got data=%h idx=%0d last=%0b, required %h %0d %0b",
                     i, got_data[i], got_idx[i], got_last[i], sent[(i / 8) * 8 + a], a, i % 8 == 7);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] sent[32];
      bit mode[4];
      int w, a, total = 0, gaps = 0, e0;
      e0 = err_seen;
      clear_got();
      m_ready = 1'b1;
      for (int f = 0; f < 4; f++) mode[f] = bit'($urandom_range(0, 1));
      for (int k = 0; k < 32; k++) begin
         sent[k] = $urandom;
         send_beat(sent[k], (k % 8) == 7, mode[k / 8], w);
         total += w;
      end
      wait_got(32);
      checks++;
      if (total != 32) begin
         fails++;
         $display("[TB] FAIL b2b_input_rate: 32 beats took %0d cycles, required 32", total);
      end
      for (int i = 1; i < 32; i++) if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
      checks++;
      if (gaps != 0) begin
         fails++;
         $display("[TB] FAIL b2b_output_gaps: got %0d gaps, required 0", gaps);
      end
      checks++;
      if (err_seen - e0 != 0) begin
         fails++;
         $display("[TB] FAIL b2b_err: got %0d frame_err pulses, required 0", err_seen - e0);
      end
      for (int i = 0; i < 32; i++) begin
         a = mode[i / 8] ? bitrev_model(i % 8, 3) : i % 8;
         checks++;
         if (got_data[i] !== sent[(i / 8) * 8 + a] || got_idx[i] !== a || got_last[i] !== (i % 8 == 7)) begin
            fails++;
            $display("[TB] FAIL b2b[%0d]: got data=%h idx=%0d last=%0b, required %h %0d %0b",
                     i, got_data[i], got_idx[i], got_last[i], sent[(i / 8) * 8 + a], a, i % 8 == 7);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] sent[16];
      bit mode[2];
      int w, a, total = 0, k = 0, s0;
      s0 = stall_viol;
      clear_got();
      m_ready = 1'b0;
      mode[0] = bit'($urandom_range(0, 1));
      mode[1] = bit'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
         sent[i] = $urandom;
         send_beat(sent[i], (i % 8) == 7, mode[i / 8], w);
         total += w;
      end
      checks++;
      if (total != 16 || s_ready !== 1'b0) begin
         fails++;
         $display("[TB] FAIL bp_fill: 16 beats took %0d cycles with s_ready=%b after, required 16 and 0",
                  total, s_ready);
      end
      repeat (6) @(posedge clk);
      #1;
      while (got_data.size() < 16 && k < 400) begin
         m_ready = bit'($urandom_range(0, 1));
         @(posedge clk); #1;
         k++;
      end
      m_ready = 1'b1;
      checks++;
      if (got_data.size() != 16) begin
         fails++;
         $display("[TB] FAIL bp_drain: got %0d samples, required 16", got_data.size());
      end
      checks++;
      if (stall_viol - s0 != 0) begin
         fails++;
         $display("[TB] FAIL bp_stable: got %0d output changes while stalled, required 0", stall_viol - s0);
      end
      for (int i = 0; i < 16; i++) begin
         a = mode[i / 8] ? bitrev_model(i % 8, 3) : i % 8;
         checks++;
         if (got_data[i] !== sent[(i / 8) * 8 + a] || got_idx[i] !== a || got_last[i] !== (i % 8 == 7)) begin
            fails++;
            $display("[TB] FAIL bp[%0d]: got data=%h idx=%0d last=%0b, required %h %0d %0b",
                     i, got_data[i], got_idx[i], got_last[i], sent[(i / 8) * 8 + a], a, i % 8 == 7);
         end
      end
   endtask

   task automatic test_frame_err();
      logic [DW-1:0] sent[8];
      int w, a, e0;
      e0 = err_seen;
      clear_got();
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sent[k] = $urandom;
         send_beat(sent[k], k == 4, 1'b1, w);
      end
      wait_got(8);
      @(posedge clk); #1;
      checks++;
      if (err_seen - e0 != 2) begin
         fails++;
         $display("[TB] FAIL frame_err_count: got %0d pulses, required 2", err_seen - e0);
      end
      for (int i = 0; i < 8; i++) begin
         a = bitrev_model(i, 3);
         checks++;
         if (got_data[i] !== sent[a] || got_idx[i] !== a || got_last[i] !== (i == 7)) begin
            fails++;
            $display("[TB] FAIL frame_err_order[%0d]: got data=%h idx=%0d, required %h %0d",
                     i, got_data[i], got_idx[i], sent[a], a);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [DW-1:0] sent[8];
      int w, a;
      m_ready = 1'b1;
      for (int k = 0; k < 5; k++) send_beat($urandom, 1'b0, 1'b1, w);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_mid_write: m_valid=%b s_ready=%b, required 0 1", m_valid, s_ready);
      end
      m_ready = 1'b0;
      for (int k = 0; k < 8; k++) send_beat($urandom, k == 7, 1'b0, w);
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_mid_pre: m_valid=%b, required 1", m_valid);
      end
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_mid_read: m_valid=%b s_ready=%b, required 0 1", m_valid, s_ready);
      end
      clear_got();
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sent[k] = $urandom;
         send_beat(sent[k], k == 7, 1'b1, w);
      end
      wait_got(8);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (got_data.size() != 8) begin
         fails++;
         $display("[TB] FAIL reset_stale: got %0d samples, required 8", got_data.size());
      end
      for (int i = 0; i < 8; i++) begin
         a = bitrev_model(i, 3);
         checks++;
         if (got_data[i] !== sent[a] || got_idx[i] !== a || got_last[i] !== (i == 7)) begin
            fails++;
            $display("[TB] FAIL reset_after[%0d]: got data=%h idx=%0d, required %h %0d",
                     i, got_data[i], got_idx[i], sent[a], a);
         end
      end
   endtask

   task automatic test_random_n9();
      logic [DW-1:0] sent[1536];
      int a, k = 0;
      m_ready_9 = 1'b1;
      for (int i = 0; i < 1536; i++) begin
         sent[i] = $urandom;
         send_beat9(sent[i], (i % 512) == 511);
      end
      while (got9_data.size() < 1536 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (got9_data.size() != 1536 || err9_seen != 0) begin
         fails++;
         $display("[TB] FAIL n9_count: got %0d samples and %0d frame_err, required 1536 and 0",
                  got9_data.size(), err9_seen);
      end
      for (int i = 0; i < 1536; i++) begin
         a = bitrev_model(i % 512, 9);
         checks++;
         if (got9_data[i] !== sent[(i / 512) * 512 + a] || got9_idx[i] !== a ||
             got9_last[i] !== (i % 512 == 511)) begin
            fails++;
            $display("[TB] FAIL n9[%0d]: got data=%h idx=%0d last=%0b, required %h %0d %0b",
                     i, got9_data[i], got9_idx[i], got9_last[i], sent[(i / 512) * 512 + a], a,
                     i % 512 == 511);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bitrev_basic();
      test_mode_switch();
      test_back_to_back();
      test_backpressure();
      test_frame_err();
      test_reset_midframe();
      test_random_n9();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
